aes_load_sequencer: RTL and testbench
=====================================

# aes_load_sequencer

Request-side controller for `aes_engine`. It accepts a 128-bit plaintext and 128-bit key in one valid/ready transfer, then serialises them MSB-byte-first onto the engine's byte-wide `din`/`cmd` interface. It issues the start command, waits for `engine_done` under a timeout, and returns a one-cycle completion pulse. An optional key-reuse path skips the key load when the engine already holds the key.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum number of cycles `cmd`=START is held waiting for `eng_done` (range 1–65535).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `req_pt` in 128: plaintext; bits [127:120] are sent first.
- `req_key` in 128: key; bits [127:120] are sent first.
- `req_reuse_key` in 1: skip the key load if a key is already loaded.
- `eng_din` out 8: byte to engine `din`.
- `eng_cmd` out 2: command to engine `cmd`. Encodings: 00 IDLE, 01 SET_PT, 10 SET_KEY, 11 START.
- `eng_ready` in 1: engine `interface_ready`.
- `eng_done` in 1: engine `engine_done`.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_timeout` out 1: qualifies `resp_valid`; high when the operation timed out.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, LOAD_PT, GAP_PT, LOAD_KEY, GAP_KEY, RUN, FINISH.
- All outputs are registered.
- `eng_din` is 00 in every state except LOAD_PT and LOAD_KEY.
- IDLE:
  - `req_ready` = `eng_ready`.
  - On `req_valid && req_ready`, capture `req_pt`, `req_key` and `req_reuse_key` into internal registers, clear the byte counter, and go to LOAD_PT.
- LOAD_PT: 16 cycles with `eng_cmd`=01. In cycle i (i=0..15), `eng_din` = pt[127-8i -: 8]. Then go to GAP_PT.
- GAP_PT: 1 cycle with `eng_cmd`=00. Next state is RUN if captured reuse=1 and `key_loaded`=1; otherwise LOAD_KEY.
- LOAD_KEY: 16 cycles with `eng_cmd`=10, key bytes in the same order as the plaintext. Then go to GAP_KEY.
- GAP_KEY: 1 cycle with `eng_cmd`=00. Set `key_loaded`. Go to RUN.
- RUN:
  - `eng_cmd`=11; the run counter increments each cycle.
  - At an edge where `eng_done`=1, go to FINISH with timeout=0.
  - Otherwise, if the counter has reached `TIMEOUT_CYCLES`, go to FINISH with timeout=1 and clear `key_loaded`.
  - If `eng_done` and the timeout occur on the same edge, `eng_done` wins.
- FINISH: 1 cycle with `eng_cmd`=00, `resp_valid`=1, and `resp_timeout` = the timeout flag. Go to IDLE.
- `eng_done` is ignored outside RUN.
- `eng_ready` is sampled only in IDLE. Dropping it mid-sequence has no effect.
- `req_reuse_key`=1 with `key_loaded`=0 performs a full key load.
- Reset, asynchronous and usable at any time including mid-sequence:
  - State returns to IDLE and `key_loaded` is cleared.
  - `eng_cmd`=00, `eng_din`=00, `req_ready`=0, `resp_valid`=0, `resp_timeout`=0, `busy`=0.
  - `req_ready` may rise on the first edge after reset is released, if `eng_ready`=1.

## Timing
- Let T be the accepting edge.
- Plaintext bytes appear on `eng_cmd`/`eng_din` in the cycles following edges T+1..T+16.
- Plaintext gap: T+17.
- Full key load: key bytes T+18..T+33, key gap T+34, START from T+35.
- Key reuse: START from T+18.
- RUN lasts from 1 to `TIMEOUT_CYCLES` cycles.
- `resp_valid` is asserted the cycle after `eng_done` is sampled.
- `req_ready` is asserted again the cycle after `resp_valid`, giving back-to-back requests one dead cycle (FINISH).
- Throughput: 1 request per (36 + run + 1) cycles with a key load, or (19 + run + 1) cycles with reuse.

## Test plan
1. Full load:
   - Stimulus: pt=00041214120412000C00131108231919, key=2475A2B3347556883 1E2120013AA5487 (i.e. 2475A2B334755688 31E2120013AA5487), `eng_ready`=1; `eng_done` pulsed on the 9th START cycle.
   - Required: 16×(01, 00,04,12,…,19); one 00; 16×(10, 24,75,…,87); one 00; 9×11; then `resp_valid`=1 with `resp_timeout`=0.
2. Key reuse:
   - Stimulus: repeat test 1 with `req_reuse_key`=1.
   - Required: no cmd=10 cycles; START begins at T+18.
3. Timeout:
   - Stimulus: `TIMEOUT_CYCLES`=4, `eng_done` held 0.
   - Required: exactly 4 cycles of cmd=11; then `resp_valid`=1 with `resp_timeout`=1. A following reuse request performs a full key load.
4. Handshake gating:
   - Stimulus: `eng_ready`=0 with `req_valid`=1 for 5 cycles.
   - Required: `req_ready`=0 and cmd=00 throughout. When `eng_ready` rises, the request is accepted on the next edge.
5. Mid-sequence reset:
   - Stimulus: assert `rst_` during key byte 7.
   - Required: all outputs return to their reset values immediately. A subsequent reuse request performs a full key load.
6. Early done:
   - Stimulus: `eng_done`=1 throughout LOAD_PT, then held through the first START cycle.
   - Required: `eng_done` is ignored during loading; exactly 1 START cycle; `resp_valid`=1 with `resp_timeout`=0.

Source files
------------

// File: rtl/aes_load_sequencer.sv
// ---------------------------------------------------------------------------
// aes_load_sequencer
//
// Request-side controller for aes_engine. A single valid/ready transfer hands
// over a 128-bit plaintext and key. The sequencer then streams them MSB byte
// first onto the engine's byte-wide din/cmd interface, issues START, waits for
// engine_done under a timeout, and returns a one-cycle completion pulse. When
// the requester asks for key reuse and the engine still holds a key, the key
// load is skipped.
//
// Parameters:
//   TIMEOUT_CYCLES - max cycles START is held waiting for eng_done (1..65535)
//
// Ports:
//   clk           in   single clock, rising edge
//   rst_          in   asynchronous, active-high reset
//   req_valid     in   request present
//   req_ready     out  sequencer can accept a request
//   req_pt        in   128-bit plaintext, [127:120] sent first
//   req_key       in   128-bit key, [127:120] sent first
//   req_reuse_key in   skip the key load if a key is already loaded
//   eng_din       out  byte to engine din
//   eng_cmd       out  engine cmd (00 IDLE, 01 SET_PT, 10 SET_KEY, 11 START)
//   eng_ready     in   engine interface_ready (sampled only while idle)
//   eng_done      in   engine engine_done (only observed while running)
//   resp_valid    out  one-cycle completion pulse
//   resp_timeout  out  qualifies resp_valid, high when the run timed out
//   busy          out  high in every state except IDLE
// ---------------------------------------------------------------------------
module aes_load_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_pt,
    input  logic [127:0] req_key,
    input  logic         req_reuse_key,
    output logic [7:0]   eng_din,
    output logic [1:0]   eng_cmd,
    input  logic         eng_ready,
    input  logic         eng_done,
    output logic         resp_valid,
    output logic         resp_timeout,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_PT,
        GAP_PT,
        LOAD_KEY,
        GAP_KEY,
        RUN,
        FINISH
    } state_t;

    localparam logic [1:0] CMD_IDLE    = 2'b00;
    localparam logic [1:0] CMD_SET_PT  = 2'b01;
    localparam logic [1:0] CMD_SET_KEY = 2'b10;
    localparam logic [1:0] CMD_START   = 2'b11;

    localparam logic [15:0] RUN_LIMIT = TIMEOUT_CYCLES[15:0];

    state_t       state;
    logic [127:0] pt_sr;
    logic [127:0] key_sr;
    logic         reuse_q;
    logic         key_loaded;
    logic [3:0]   byte_cnt;
    logic [15:0]  run_cnt;

    // Single sequencer process. Every output is a register written alongside
    // the state, so the engine sees glitch-free cmd/din. The plaintext and key
    // are held in shift registers: the byte on top is always the next one to
    // send, which avoids a wide 16:1 byte multiplexer.
    //
    // In RUN, run_cnt counts START cycles already placed on the bus. eng_done
    // is only honoured once at least one START cycle has been driven, so the
    // engine always sees START before the sequencer can complete. eng_done is
    // checked before the timeout so a simultaneous done wins. A timeout drops
    // key_loaded because the engine's key state can no longer be trusted.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state        <= IDLE;
            pt_sr        <= '0;
            key_sr       <= '0;
            reuse_q      <= 1'b0;
            key_loaded   <= 1'b0;
            byte_cnt     <= '0;
            run_cnt      <= '0;
            req_ready    <= 1'b0;
            eng_din      <= 8'h00;
            eng_cmd      <= CMD_IDLE;
            resp_valid   <= 1'b0;
            resp_timeout <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    eng_cmd      <= CMD_IDLE;
                    eng_din      <= 8'h00;
                    resp_valid   <= 1'b0;
                    resp_timeout <= 1'b0;
                    if (req_valid && req_ready) begin
                        pt_sr     <= req_pt;
                        key_sr    <= req_key;
                        reuse_q   <= req_reuse_key;
                        byte_cnt  <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= LOAD_PT;
                    end else begin
                        req_ready <= eng_ready;
                    end
                end

                LOAD_PT: begin
                    eng_cmd  <= CMD_SET_PT;
                    eng_din  <= pt_sr[127:120];
                    pt_sr    <= {pt_sr[119:0], 8'h00};
                    byte_cnt <= byte_cnt + 4'd1;
                    if (byte_cnt == 4'd15) begin
                        state <= GAP_PT;
                    end
                end

                GAP_PT: begin
                    eng_cmd  <= CMD_IDLE;
                    eng_din  <= 8'h00;
                    byte_cnt <= '0;
                    run_cnt  <= '0;
                    if (reuse_q && key_loaded) begin
                        state <= RUN;
                    end else begin
                        state <= LOAD_KEY;
                    end
                end

                LOAD_KEY: begin
                    eng_cmd  <= CMD_SET_KEY;
                    eng_din  <= key_sr[127:120];
                    key_sr   <= {key_sr[119:0], 8'h00};
                    byte_cnt <= byte_cnt + 4'd1;
                    if (byte_cnt == 4'd15) begin
                        state <= GAP_KEY;
                    end
                end

                GAP_KEY: begin
                    eng_cmd    <= CMD_IDLE;
                    eng_din    <= 8'h00;
                    key_loaded <= 1'b1;
                    run_cnt    <= '0;
                    state      <= RUN;
                end

                RUN: begin
                    eng_din <= 8'h00;
                    if ((run_cnt != 16'd0) && eng_done) begin
                        eng_cmd      <= CMD_IDLE;
                        resp_valid   <= 1'b1;
                        resp_timeout <= 1'b0;
                        state        <= FINISH;
                    end else if (run_cnt >= RUN_LIMIT) begin
                        eng_cmd      <= CMD_IDLE;
                        resp_valid   <= 1'b1;
                        resp_timeout <= 1'b1;
                        key_loaded   <= 1'b0;
                        state        <= FINISH;
                    end else begin
                        eng_cmd <= CMD_START;
                        run_cnt <= run_cnt + 16'd1;
                    end
                end

                FINISH: begin
                    eng_cmd      <= CMD_IDLE;
                    eng_din      <= 8'h00;
                    resp_valid   <= 1'b0;
                    resp_timeout <= 1'b0;
                    busy         <= 1'b0;
                    req_ready    <= eng_ready;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_load_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_load_sequencer
//
// Self-checking bench for aes_load_sequencer. Two instances share every input
// except req_valid: dut_a uses the default timeout, dut_b uses a timeout of 4.
// For each request the bench builds the full expected per-cycle output stream
// (cmd, din, resp_valid, resp_timeout, req_ready, busy) into a queue at the
// accepting edge, then pops one entry per cycle and compares it against the
// selected instance. A bench-side key_loaded model per instance decides
// whether a reuse request should skip the key load.
// ---------------------------------------------------------------------------
module tb_aes_load_sequencer;

    logic         clk = 1'b0;
    logic         rst_;
    logic         req_valid_a;
    logic         req_valid_b;
    logic [127:0] req_pt;
    logic [127:0] req_key;
    logic         req_reuse_key;
    logic         eng_ready;
    logic         eng_done;

    logic         req_ready_a, req_ready_b;
    logic [7:0]   eng_din_a, eng_din_b;
    logic [1:0]   eng_cmd_a, eng_cmd_b;
    logic         resp_valid_a, resp_valid_b;
    logic         resp_timeout_a, resp_timeout_b;
    logic         busy_a, busy_b;

    int checks   = 0;
    int failures = 0;
    bit kl_a     = 1'b0;
    bit kl_b     = 1'b0;
    int waited;

    logic [15:0] exp_q[$];

    localparam logic [127:0] PT1  = 128'h00041214120412000C00131108231919;
    localparam logic [127:0] KEY1 = 128'h2475A2B33475568831E2120013AA5487;
    localparam logic [127:0] PT2  = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    localparam logic [127:0] KEY2 = 128'h0123456789ABCDEFFEDCBA9876543210;

    always #5 clk = ~clk;

    aes_load_sequencer dut_a (
        .clk           (clk),
        .rst_          (rst_),
        .req_valid     (req_valid_a),
        .req_ready     (req_ready_a),
        .req_pt        (req_pt),
        .req_key       (req_key),
        .req_reuse_key (req_reuse_key),
        .eng_din       (eng_din_a),
        .eng_cmd       (eng_cmd_a),
        .eng_ready     (eng_ready),
        .eng_done      (eng_done),
        .resp_valid    (resp_valid_a),
        .resp_timeout  (resp_timeout_a),
        .busy          (busy_a)
    );

    aes_load_sequencer #(.TIMEOUT_CYCLES(4)) dut_b (
        .clk           (clk),
        .rst_          (rst_),
        .req_valid     (req_valid_b),
        .req_ready     (req_ready_b),
        .req_pt        (req_pt),
        .req_key       (req_key),
        .req_reuse_key (req_reuse_key),
        .eng_din       (eng_din_b),
        .eng_cmd       (eng_cmd_b),
        .eng_ready     (eng_ready),
        .eng_done      (eng_done),
        .resp_valid    (resp_valid_b),
        .resp_timeout  (resp_timeout_b),
        .busy          (busy_b)
    );

    // Packs one cycle of outputs: [13:12] cmd, [11:4] din, [3] resp_valid,
    // [2] resp_timeout, [1] req_ready, [0] busy.
    function automatic logic [15:0] pack(input logic [1:0] c, input logic [7:0] d,
                                         input logic rv, input logic rt,
                                         input logic rr, input logic bz);
        return {2'b00, c, d, rv, rt, rr, bz};
    endfunction

    function automatic logic [15:0] observe(input bit sel);
        if (sel) begin
            return pack(eng_cmd_b, eng_din_b, resp_valid_b, resp_timeout_b, req_ready_b, busy_b);
        end
        return pack(eng_cmd_a, eng_din_a, resp_valid_a, resp_timeout_a, req_ready_a, busy_a);
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h required=%h", tag, actual, expected);
        end
    endtask

    // Issues one request to the selected instance and checks every output
    // cycle until the sequencer is back in IDLE. done_cycle selects the START
    // cycle (1-based) during which eng_done is raised, 0 for never. early
    // raises eng_done throughout plaintext loading. abort_at >= 0 asserts
    // reset mid-cycle after that stream index has been checked.
    task automatic applyStimulus(input bit sel, input logic [127:0] pt,
                                 input logic [127:0] key, input bit reuse,
                                 input int done_cycle, input bit early,
                                 input int abort_at, output int wait_cycles);
        int          tmo;
        bit          kl;
        bit          full;
        int          starts;
        bit          to;
        bit          accepted;
        int          idx;
        int          start_seen;
        logic [15:0] obs;
        logic [15:0] e;
        logic [1:0]  c;

        tmo  = sel ? 4 : 64;
        kl   = sel ? kl_b : kl_a;
        full = !(reuse && kl);

        req_pt        = pt;
        req_key       = key;
        req_reuse_key = reuse;
        if (sel) req_valid_b = 1'b1;
        else     req_valid_a = 1'b1;

        wait_cycles = 0;
        accepted    = 1'b0;
        while (!accepted && wait_cycles < 20) begin
            @(posedge clk);
            #1;
            wait_cycles++;
            obs = observe(sel);
            if (obs[0]) accepted = 1'b1;
        end
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        checkOutput("accept", obs, pack(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        if (!accepted) return;

        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(pack(2'b01, pt[127-8*i -: 8], 0, 0, 0, 1));
        exp_q.push_back(pack(2'b00, 8'h00, 0, 0, 0, 1));
        if (full) begin
            for (int i = 0; i < 16; i++) exp_q.push_back(pack(2'b10, key[127-8*i -: 8], 0, 0, 0, 1));
            exp_q.push_back(pack(2'b00, 8'h00, 0, 0, 0, 1));
        end
        if (done_cycle > 0 && done_cycle <= tmo) begin
            starts = done_cycle;
            to     = 1'b0;
        end else begin
            starts = tmo;
            to     = 1'b1;
        end
        for (int i = 0; i < starts; i++) exp_q.push_back(pack(2'b11, 8'h00, 0, 0, 0, 1));
        exp_q.push_back(pack(2'b00, 8'h00, 1'b1, to, 1'b0, 1'b1));
        exp_q.push_back(pack(2'b00, 8'h00, 1'b0, 1'b0, eng_ready, 1'b0));

        eng_done   = early;
        idx        = 0;
        start_seen = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e   = exp_q.pop_front();
            obs = observe(sel);
            checkOutput($sformatf("%s_cyc%0d", sel ? "b" : "a", idx), obs, e);
            if (idx == abort_at) begin
                #1;
                rst_ = 1'b1;
                #1;
                checkOutput("reset_async", observe(sel), pack(2'b00, 8'h00, 0, 0, 0, 0));
                exp_q.delete();
                kl_a     = 1'b0;
                kl_b     = 1'b0;
                eng_done = 1'b0;
                return;
            end
            c = e[13:12];
            if (c == 2'b11) start_seen++;
            eng_done = ((c == 2'b11) && (start_seen == done_cycle)) || (early && (c == 2'b01));
            idx++;
        end
        eng_done = 1'b0;

        if (full) kl = 1'b1;
        if (to)   kl = 1'b0;
        if (sel) kl_b = kl;
        else     kl_a = kl;
    endtask

    initial begin
        rst_          = 1'b1;
        req_valid_a   = 1'b0;
        req_valid_b   = 1'b0;
        req_pt        = '0;
        req_key       = '0;
        req_reuse_key = 1'b0;
        eng_ready     = 1'b1;
        eng_done      = 1'b0;

        #12;
        checkOutput("reset_a", observe(0), pack(2'b00, 8'h00, 0, 0, 0, 0));
        checkOutput("reset_b", observe(1), pack(2'b00, 8'h00, 0, 0, 0, 0));
        @(negedge clk);
        rst_ = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_after_reset", observe(0), pack(2'b00, 8'h00, 0, 0, 1, 0));

        // Full load, done on the 9th START cycle.
        applyStimulus(0, PT1, KEY1, 1'b0, 9, 1'b0, -1, waited);
        // Key reuse: START right after the plaintext gap.
        applyStimulus(0, PT1, KEY1, 1'b1, 9, 1'b0, -1, waited);

        // Timeout on the short-timeout instance, then reuse must reload.
        applyStimulus(1, PT2, KEY2, 1'b0, 2, 1'b0, -1, waited);
        applyStimulus(1, PT2, KEY2, 1'b1, 0, 1'b0, -1, waited);
        applyStimulus(1, PT1, KEY1, 1'b1, 3, 1'b0, -1, waited);
        // Done on the same edge as the timeout: done wins.
        applyStimulus(1, PT2, KEY1, 1'b1, 4, 1'b0, -1, waited);

        // Handshake gating with eng_ready low.
        eng_ready = 1'b0;
        @(posedge clk);
        #1;
        req_pt      = PT2;
        req_key     = KEY2;
        req_valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("gate%0d", i), observe(0), pack(2'b00, 8'h00, 0, 0, 0, 0));
        end
        eng_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_rise", observe(0), pack(2'b00, 8'h00, 0, 0, 1, 0));
        applyStimulus(0, PT2, KEY2, 1'b0, 5, 1'b0, -1, waited);
        checkOutput("accept_latency", 16'(waited), 16'd1);

        // Reset during key byte 7 (stream index 17 + 7).
        applyStimulus(0, PT1, KEY2, 1'b0, 3, 1'b0, 24, waited);
        repeat (2) @(negedge clk);
        rst_ = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_after_mid_reset", observe(0), pack(2'b00, 8'h00, 0, 0, 1, 0));
        applyStimulus(0, PT2, KEY1, 1'b1, 2, 1'b0, -1, waited);

        // Early done: ignored while loading, exactly one START cycle.
        applyStimulus(0, PT1, KEY1, 1'b0, 1, 1'b1, -1, waited);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
